// File: rtl/bus_line16_pkg.sv
// Shared types and defaults for the bus_line16 pulse driver.
package bus_line16_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage : bus_line16_pkg

// File: rtl/bus_line16_if.sv
// Word/strobe side and the sixteen individual pulse lines of bus_line16.
interface bus_line16_if;
    import bus_line16_pkg::*;

    word_t din;
    logic  load;
    logic  busy;
    logic  done;
    logic  o0,  o1,  o2,  o3,  o4,  o5,  o6,  o7;
    logic  o8,  o9,  o10, o11, o12, o13, o14, o15;

    modport master (
        output din, load,
        input  busy, done,
        input  o0, o1, o2, o3, o4, o5, o6, o7,
        input  o8, o9, o10, o11, o12, o13, o14, o15
    );

    modport slave (
        input  din, load,
        output busy, done,
        output o0, o1, o2, o3, o4, o5, o6, o7,
        output o8, o9, o10, o11, o12, o13, o14, o15
    );

endinterface : bus_line16_if

// File: rtl/bus_line16_pulse_timer.sv
// Loadable down-counter with a zero flag; times both the pulse and the gap.
// Counting stops at zero, so the count never wraps.
module pulse_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register with asynchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : pulse_timer

// File: rtl/bus_line16.sv
// bus_line16: drives a loaded 16-bit word onto 16 single-bit lines as a
// PULSE_LEN-cycle pulse followed by a GAP_LEN-cycle all-low gap.
// Optional build macro BUS_LINE16_RETRIG_EN: a load during HOLD or GAP
// restarts the frame with the new word; otherwise such loads are ignored.
module bus_line16
    import bus_line16_pkg::*;
#(
    parameter int PULSE_LEN = 8,
    parameter int GAP_LEN   = 2,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    bus_line16_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_LEN - 1);

    state_t           state_q, state_d;
    word_t            word_q,  word_d;
    word_t            lines_q, lines_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_en;
    logic             tmr_zero;

    pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .en_i    (tmr_en),
        .zero_o  (tmr_zero)
    );

    // Next state, next line values and timer control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        word_d    = word_q;
        lines_d   = lines_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = HOLD_CNT;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    word_d   = bus.din;
                    lines_d  = bus.din;
                    tmr_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    lines_d   = '0;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_CNT;
                    state_d   = GAP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                lines_d = '0;
                state_d = IDLE;
            end
        endcase

`ifdef BUS_LINE16_RETRIG_EN
        // Retrigger: abandon the running frame silently and start a new one.
        if ((state_q != IDLE) && bus.load) begin
            word_d    = bus.din;
            lines_d   = bus.din;
            done_d    = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = HOLD_CNT;
            tmr_en    = 1'b0;
            state_d   = HOLD;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // State, word and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lines_q <= lines_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.o0   = lines_q[0];
    assign bus.o1   = lines_q[1];
    assign bus.o2   = lines_q[2];
    assign bus.o3   = lines_q[3];
    assign bus.o4   = lines_q[4];
    assign bus.o5   = lines_q[5];
    assign bus.o6   = lines_q[6];
    assign bus.o7   = lines_q[7];
    assign bus.o8   = lines_q[8];
    assign bus.o9   = lines_q[9];
    assign bus.o10  = lines_q[10];
    assign bus.o11  = lines_q[11];
    assign bus.o12  = lines_q[12];
    assign bus.o13  = lines_q[13];
    assign bus.o14  = lines_q[14];
    assign bus.o15  = lines_q[15];

endmodule : bus_line16

// File: doc/bus_line16.md
Name: bus_line16

Overview:
- Counterpart of the 16-line gatherer: takes a 16-bit word and drives it back out onto 16 individual single-bit lines o0..o15.
- Each set bit becomes a timed pulse of PULSE_LEN clocks, followed by a mandatory low gap of GAP_LEN clocks.
- Sits on the synchronisation-pulse distribution path, between the control register bank and the per-channel strobe lines.

Parameters:
- PULSE_LEN, 8, high time of each asserted line in clk cycles; legal 1..2^CNT_W-1.
- GAP_LEN, 2, forced all-low time after each pulse in clk cycles; legal 1..2^CNT_W-1.
- CNT_W, 8, width of the internal down-counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  16  word to emit; bit k drives line ok.
- load  input  1  request strobe; sampled on clk.
- busy  output  1  high while a pulse or gap is in progress.
- done  output  1  one-cycle strobe on return to IDLE.
- o0 .. o15  output  1 each  individual output lines; all registered.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - o0..o15=0, busy=0, done=0.
  - State=IDLE, counter=0, word register=0.
- States: IDLE, HOLD, GAP. busy = (state != IDLE), registered.
- IDLE with load=1 at edge N:
  - word<=din, counter<=PULSE_LEN-1, state<=HOLD.
  - From edge N onward, ok=din[k] and busy=1. Latency is 1 cycle, matching the gatherer.
- HOLD:
  - Lines hold the word; counter decrements each cycle.
  - At counter==0: lines<=0, counter<=GAP_LEN-1, state<=GAP.
  - Lines are high for exactly PULSE_LEN cycles.
- GAP:
  - Lines stay 0; counter decrements.
  - At counter==0: state<=IDLE, done<=1 for exactly one cycle.
- Busy window: busy is high for exactly PULSE_LEN+GAP_LEN cycles per accepted load.
- load while busy (macro off): ignored entirely. Word, counter and state are unchanged, and no queueing occurs.
- load in the same cycle that done is high: state is IDLE, so the load is accepted. done=1 and busy=1 on the following edge is not possible; busy rises on the edge after the load.
- load held continuously: back-to-back frames, each separated by GAP_LEN low cycles and one IDLE cycle.
- din=0 on load: full timing runs (busy, done) with all lines low.
- PULSE_LEN=1: lines are high for exactly one cycle.
- Counter: CNT_W bits, down-count only, no wrap. The transition happens on ==0 before any decrement below zero.
- din is sampled only on accepted loads; changes to din at other times have no effect on the outputs.

Optional Feature:
- Macro: BUS_LINE16_RETRIG_EN.
- Defined: load in HOLD or GAP is accepted.
  - word<=din, counter<=PULSE_LEN-1, state<=HOLD.
  - Lines take the new word on the next edge; no done is issued for the aborted frame.
  - A load in the terminal GAP cycle (counter==0) also retriggers: no done, state goes to HOLD.
- Undefined: load while busy is ignored, as stated in Behaviour.

Decomposition:
- Package bus_line16_pkg holds:
  - state typedef (IDLE=2'd0, HOLD=2'd1, GAP=2'd2);
  - CNT_W default;
  - a 16-bit word typedef.
- One natural sub-module: pulse_timer, a loadable CNT_W-bit down-counter with a zero flag, instantiated once and reused for both HOLD and GAP.
- The FSM and the output register stay in bus_line16.

Test Plan:
- Reset then idle 20 cycles -> all o*=0, busy=0, done never asserted.
- Defaults, load with din=16'hA5C3 at cycle 10:
  - cycles 11..18: {o15..o0}=A5C3;
  - cycles 19..20: 0;
  - done=1 at cycle 21;
  - busy=1 for cycles 11..20.
- load with din=16'h0001 at cycle 10, second load with din=16'hFFFF at cycle 14:
  - macro off: only o0 pulses (cycles 11..18); the second load is ignored.
  - macro on: o0 for cycles 11..14, then 16'hFFFF for cycles 15..22, a single done at cycle 25.
- load held high continuously with din=16'h8000 -> o15 pulses 8 high, 2 low, with a 1-cycle IDLE between frames; period 11 cycles.
- rst asserted asynchronously between clock edges at the middle of HOLD (cycle 14.5) -> outputs 0 immediately, busy=0; the next load after reset release behaves as a fresh frame.
- PULSE_LEN=1, GAP_LEN=1, load with din=16'h00F0 -> o4..o7 high for exactly 1 cycle, done 2 cycles after busy rises.
